// File: rtl/layer_seq_ctrl.sv
// Layer sequencer for a LUT-based neuron layer: evaluates one neuron per cycle by
// gathering its fan-in features through a connectivity map and reading its truth table.
module layer_seq_ctrl #(
   parameter int NUM_NEURONS = 16,
   parameter int NUM_FEAT    = 32,
   parameter int FANIN       = 4,
   parameter int IN_BITS     = 2,
   parameter int OUT_BITS    = 2,
   parameter int AW          = FANIN * IN_BITS,
   parameter int IW          = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1,
   parameter int NW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   parameter int CW          = (OUT_BITS > IW) ? OUT_BITS : IW
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [NUM_FEAT*IN_BITS-1:0]     s_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [NUM_NEURONS*OUT_BITS-1:0] m_data,
   input  logic                            cfg_valid,
   output logic                            cfg_ready,
   input  logic                            cfg_sel,
   input  logic [NW-1:0]                   cfg_neuron,
   input  logic [AW-1:0]                   cfg_addr,
   input  logic [CW-1:0]                   cfg_data,
   output logic                            busy
);

   localparam int SW = (FANIN > 1) ? $clog2(FANIN) : 1;
   localparam logic [NW-1:0] LAST = NW'(NUM_NEURONS - 1);

   typedef enum logic [1:0] {IDLE, EVAL, DRAIN, OUT} state_t;

   state_t                      state, state_nx;
   logic [NW-1:0]               n;
   logic [NUM_FEAT*IN_BITS-1:0] vec;
   logic [IW-1:0]               conn [NUM_NEURONS][FANIN];
   logic [OUT_BITS-1:0]         tbl  [NUM_NEURONS][2**AW];
   logic [AW-1:0]               addr_n;
   logic                        accept, cfg_wr;
   logic                        vld_p0, vld_p1;
   logic [NW-1:0]               nrn_p0, nrn_p1;
   logic [AW-1:0]               addr_p0;
   logic [OUT_BITS-1:0]         rd_data_p1;

   // Indices beyond the feature vector read as zero.
   function automatic logic [IN_BITS-1:0] feat_sel(input logic [NUM_FEAT*IN_BITS-1:0] v,
                                                   input logic [IW-1:0] idx);
      logic [IN_BITS-1:0] r;
      r = '0;
      for (int f = 0; f < NUM_FEAT; f++)
         if (idx == IW'(f)) r = v[f*IN_BITS +: IN_BITS];
      return r;
   endfunction

   always_comb begin
      state_nx  = state;
      s_ready   = 1'b0;
      cfg_ready = 1'b0;
      m_valid   = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            s_ready   = 1'b1;
            cfg_ready = !s_valid;
            busy      = 1'b0;
            if (s_valid) state_nx = EVAL;
         end
         EVAL:    if (n == LAST) state_nx = DRAIN;
         DRAIN:   if (vld_p1 && nrn_p1 == LAST) state_nx = OUT;
         OUT: begin
            m_valid = 1'b1;
            if (m_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign accept = s_valid && s_ready;
   assign cfg_wr = cfg_valid && cfg_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         n      <= '0;
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         state  <= state_nx;
         vld_p0 <= (state == EVAL);
         vld_p1 <= vld_p0;
         if (accept)                        n <= '0;
         else if (state == EVAL && n != LAST) n <= n + 1'b1;
      end
   end

   always_ff @(posedge clk)
      if (accept) vec <= s_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_NEURONS; i++)
            for (int j = 0; j < FANIN; j++)
               conn[i][j] <= '0;
      end else if (cfg_wr && cfg_sel) begin
         conn[cfg_neuron][cfg_addr[SW-1:0]] <= cfg_data[IW-1:0];
      end
   end

   always_comb begin
      addr_n = '0;
      for (int j = 0; j < FANIN; j++)
         addr_n[j*IN_BITS +: IN_BITS] = feat_sel(vec, conn[n][j]);
   end

   // p0: table address formed from the gathered features
   always_ff @(posedge clk) begin
      addr_p0 <= addr_n;
      nrn_p0  <= n;
      nrn_p1  <= nrn_p0;
   end

   // p1: synchronous table read; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (cfg_wr && !cfg_sel) tbl[cfg_neuron][cfg_addr] <= cfg_data[OUT_BITS-1:0];
      rd_data_p1 <= tbl[nrn_p0][addr_p0];
   end

   // p2: result slice written back into the output vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data <= '0;
      end else if (vld_p1) begin
         for (int k = 0; k < NUM_NEURONS; k++)
            if (nrn_p1 == NW'(k)) m_data[k*OUT_BITS +: OUT_BITS] <= rd_data_p1;
      end
   end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl: directed scenarios followed by a random sweep.
module tb_layer_seq_ctrl;

   localparam int NN = 16;
   localparam int NF = 32;
   localparam int FI = 4;
   localparam int IB = 2;
   localparam int OB = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [63:0] s_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic        cfg_sel = 1'b0;
   logic [3:0]  cfg_neuron = '0;
   logic [7:0]  cfg_addr = '0;
   logic [4:0]  cfg_data = '0;
   logic        busy;

   layer_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
      .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   logic [1:0]  mtbl  [NN][256];
   logic [4:0]  mconn [NN][FI];
   logic [31:0] q [$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          acc_edge = 0;
   bit          prev_mv = 1'b0;
   bit          acc_flag = 1'b0;
   bit          cfg_done = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_out(input logic [63:0] v);
      logic [31:0] r;
      logic [7:0]  a;
      int          idx;
      logic [1:0]  f;
      r = '0;
      for (int k = 0; k < NN; k++) begin
         a = '0;
         for (int j = 0; j < FI; j++) begin
            idx = int'(mconn[k][j]);
            f   = (idx < NF) ? 2'((v >> (idx * IB)) & 64'h3) : 2'b00;
            a   = a | (8'(f) << (j * IB));
         end
         r = r | (32'(mtbl[k][a]) << (k * OB));
      end
      return r;
   endfunction

   // One clock: observe the handshakes that the coming edge will take, then advance.
   task automatic cycle();
      logic [31:0] exp;
      #1;
      acc_flag = 1'b0;
      if (s_valid && s_ready) begin
         q.push_back(model_out(s_data));
         acc_edge = cyc + 1;
         acc_flag = 1'b1;
      end
      if (cfg_valid && cfg_ready) begin
         if (!cfg_sel) mtbl[cfg_neuron][cfg_addr] = cfg_data[1:0];
         else          mconn[cfg_neuron][cfg_addr[1:0]] = cfg_data;
         cfg_done = 1'b1;
      end
      if (m_valid && !prev_mv) chk("latency", 64'(cyc - acc_edge), 64'd18);
      prev_mv = m_valid;
      if (m_valid && m_ready) begin
         chk("out_pending", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) begin
            exp = q.pop_front();
            chk("m_data", 64'(m_data), 64'(exp));
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic cfg_write(input logic sel, input logic [3:0] nr, input logic [7:0] ad,
                            input logic [4:0] d);
      int k = 0;
      cfg_sel = sel; cfg_neuron = nr; cfg_addr = ad; cfg_data = d;
      cfg_valid = 1'b1;
      cfg_done  = 1'b0;
      while (!cfg_done && k < 100) begin
         cycle();
         k++;
      end
      if (!cfg_done) chk("cfg_timeout", 64'(cfg_done), 64'd1);
      cfg_valid = 1'b0;
   endtask

   task automatic send(input logic [63:0] v);
      int k = 0;
      s_data  = v;
      s_valid = 1'b1;
      cycle();
      s_valid = 1'b0;
      chk("accept", 64'(acc_flag), 64'd1);
      while (!m_valid && k < 40) begin
         cycle();
         k++;
      end
      chk("m_valid_rise", 64'(m_valid), 64'd1);
      chk("rise_edge", 64'(cyc - acc_edge), 64'd18);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k;
      int  acc;
      bit  mv_seen;

      for (int i = 0; i < NN; i++)
         for (int j = 0; j < FI; j++)
            mconn[i][j] = '0;

      #12;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd1);
      chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Neuron 0 on features 0..3 with table[0x00]=2; all other reachable entries 0.
      for (int i = 1; i < NN; i++) cfg_write(1'b0, 4'(i), 8'h00, 5'd0);
      for (int j = 0; j < FI; j++) cfg_write(1'b1, 4'd0, 8'(j), 5'(j));
      cfg_write(1'b0, 4'd0, 8'h00, 5'd2);
      send(64'h0);
      chk("t1_m_data", 64'(m_data), 64'h2);
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
      chk("t1_idle", 64'(m_valid), 64'd0);

      // Neuron 3 fans in feature 5 four times; feature 5 = 3 selects table[0xFF].
      for (int j = 0; j < FI; j++) cfg_write(1'b1, 4'd3, 8'(j), 5'd5);
      cfg_write(1'b0, 4'd3, 8'hFF, 5'd1);
      send(64'h3 << 10);
      chk("t2_slice3", 64'(m_data[7:6]), 64'd1);
      chk("t2_m_data", 64'(m_data), 64'h42);

      // Output stall for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("stall_m_valid", 64'(m_valid), 64'd1);
         chk("stall_m_data", 64'(m_data), 64'h42);
         chk("stall_s_ready", 64'(s_ready), 64'd0);
         chk("stall_busy", 64'(busy), 64'd1);
      end
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
      chk("stall_release_m_valid", 64'(m_valid), 64'd0);
      chk("stall_release_s_ready", 64'(s_ready), 64'd1);
      chk("stall_release_busy", 64'(busy), 64'd0);
      chk("stall_hold_m_data", 64'(m_data), 64'h42);

      // Simultaneous input and config: input wins, config lands after the result.
      cfg_sel = 1'b0; cfg_neuron = 4'd1; cfg_addr = 8'h00; cfg_data = 5'd3;
      cfg_valid = 1'b1;
      cfg_done  = 1'b0;
      s_data  = 64'h0;
      s_valid = 1'b1;
      #1;
      chk("prio_cfg_ready", 64'(cfg_ready), 64'd0);
      chk("prio_s_ready", 64'(s_ready), 64'd1);
      cycle();
      s_valid = 1'b0;
      chk("prio_accept", 64'(acc_flag), 64'd1);
      chk("prio_cfg_held", 64'(cfg_done), 64'd0);
      m_ready = 1'b1;
      k = 0;
      while (!cfg_done && k < 60) begin
         cycle();
         k++;
      end
      cfg_valid = 1'b0;
      m_ready   = 1'b0;
      chk("prio_cfg_done", 64'(cfg_done), 64'd1);
      chk("prio_cfg_after_out", 64'(q.size()), 64'd0);
      send(64'h0);
      chk("prio_new_entry", 64'(m_data), 64'hE);
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;

      // Reset at n=7 aborts the vector; tables survive, connectivity clears.
      s_data  = 64'h0123_4567_89AB_CDEF;
      s_valid = 1'b1;
      cycle();
      s_valid = 1'b0;
      for (int i = 0; i < 7; i++) cycle();
      chk("abort_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #2;
      chk("abort_m_valid", 64'(m_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_m_data", 64'(m_data), 64'd0);
      chk("abort_s_ready", 64'(s_ready), 64'd1);
      q.delete();
      prev_mv = 1'b0;
      for (int i = 0; i < NN; i++)
         for (int j = 0; j < FI; j++)
            mconn[i][j] = '0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc += 2;
      chk("abort_first_edge_s_ready", 64'(s_ready), 64'd1);
      m_ready = 1'b1;
      mv_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (m_valid) mv_seen = 1'b1;
      end
      m_ready = 1'b0;
      chk("abort_no_result", 64'(mv_seen), 64'd0);
      send(64'h4);
      chk("abort_table_kept", 64'(m_data), 64'hE);
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;

      // Random tables and connectivity, back-to-back vectors, random output stalls.
      for (int i = 0; i < NN; i++)
         for (int a = 0; a < 256; a++)
            cfg_write(1'b0, 4'(i), 8'(a), 5'($urandom_range(0, 3)));
      for (int i = 0; i < NN; i++)
         for (int j = 0; j < FI; j++)
            cfg_write(1'b1, 4'(i), 8'(j), 5'($urandom_range(0, 31)));
      acc = 0;
      k   = 0;
      s_data  = {$urandom, $urandom};
      s_valid = 1'b1;
      while ((acc < 1000 || q.size() > 0) && k < 60000) begin
         m_ready = ($urandom_range(0, 3) != 0);
         cycle();
         k++;
         if (acc_flag) begin
            acc++;
            s_data = {$urandom, $urandom};
            if (acc == 1000) s_valid = 1'b0;
         end
      end
      m_ready = 1'b0;
      chk("sweep_vectors", 64'(acc), 64'd1000);
      chk("sweep_drained", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
